// File: rtl/clk_gen_pkg.sv
// Shared definitions for the clock generation block: ratio table access,
// ratio clamping and index-width helpers.
`ifndef CLK_GEN_DIV_AT
`define CLK_GEN_DIV_AT(list, idx, w) list[(idx)*(w) +: (w)]
`endif

package clk_gen_pkg;

    typedef enum logic {
        SEL_IDLE = 1'b0,
        SEL_PEND = 1'b1
    } sel_state_t;

    localparam int unsigned MIN_RATIO = 2;

    // Ceiling log2, never below 1 so a select port always has at least one bit.
    function automatic int unsigned clog2(input int unsigned n);
        int unsigned w;
        w = 1;
        while ((32'd1 << w) < n) w++;
        return w;
    endfunction

    function automatic int unsigned clamp_ratio(input int unsigned r);
        return (r < MIN_RATIO) ? MIN_RATIO : r;
    endfunction

endpackage

// File: rtl/clk_div_cnt.sv
// Period counter: runs 0..ratio-1 and wraps; load restarts a period at 0.
// cnt_next is exposed so the owner can register outputs in step with the count.
module clk_div_cnt #(
    parameter int unsigned      DIV_W   = 8,
    parameter logic [DIV_W-1:0] RST_CNT = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [DIV_W-1:0] ratio,
    input  logic             load,
    output logic [DIV_W-1:0] cnt_next,
    output logic             last
);

    localparam logic [DIV_W-1:0] ONE = DIV_W'(1);

    logic [DIV_W-1:0] cnt;

    assign last     = (cnt == ratio - ONE);
    assign cnt_next = (load || last) ? '0 : cnt + ONE;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of its neighbours.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= RST_CNT;
        end else begin
            cnt <= cnt_next;
        end
    end

endmodule

// File: rtl/clk_div_sel_mux.sv
// Glitch-free divided-clock selector: switches divide ratio only at period
// boundaries and emits a one-cycle clk_en strobe in the last cycle of each period.
module clk_div_sel_mux
    import clk_gen_pkg::*;
#(
    parameter int unsigned                NUM_SRC  = 4,
    parameter int unsigned                DIV_W    = 8,
    parameter logic [NUM_SRC*DIV_W-1:0]   DIV_LIST = {8'd16, 8'd8, 8'd4, 8'd2},
    parameter int unsigned                RST_SEL  = 0,
    localparam int unsigned               SEL_W    = clog2(NUM_SRC)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sel_req,
    input  logic [SEL_W-1:0] sel_idx,
    output logic             sel_busy,
    output logic             sel_done,
    output logic             sel_err,
    output logic [SEL_W-1:0] cur_sel,
    output logic             clk_out,
    output logic             clk_en
);

    localparam logic [DIV_W-1:0] ONE         = DIV_W'(1);
    localparam logic [SEL_W:0]   NUM_SRC_EXT = (SEL_W + 1)'(NUM_SRC);
    localparam logic [SEL_W-1:0] RST_SEL_V   = SEL_W'(RST_SEL);
    localparam int unsigned      RST_RATIO   =
        clamp_ratio(32'(`CLK_GEN_DIV_AT(DIV_LIST, RST_SEL, DIV_W)));
    localparam logic [DIV_W-1:0] RST_CNT     = DIV_W'(RST_RATIO - 1);

    logic [DIV_W-1:0] ratio_tab [NUM_SRC];

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_tab
        localparam int unsigned RAW = 32'(`CLK_GEN_DIV_AT(DIV_LIST, i, DIV_W));
        assign ratio_tab[i] = DIV_W'(clamp_ratio(RAW));
    end

    sel_state_t       state, state_nxt;
    logic [SEL_W-1:0] pend, pend_nxt;
    logic [SEL_W-1:0] sel_nxt;
    logic             commit, done_nxt, err_nxt;
    logic             idx_ok;
    logic             last;
    logic [DIV_W-1:0] cnt_next;
    logic [DIV_W-1:0] ratio_cur, ratio_nxt, half_nxt;

    assign idx_ok    = ({1'b0, sel_idx} < NUM_SRC_EXT);
    assign ratio_cur = ratio_tab[cur_sel];
    assign ratio_nxt = ratio_tab[sel_nxt];
    assign half_nxt  = ratio_nxt >> 1;
    assign sel_busy  = (state == SEL_PEND);

    clk_div_cnt #(
        .DIV_W   (DIV_W),
        .RST_CNT (RST_CNT)
    ) u_cnt (
        .clk      (clk),
        .rst      (rst),
        .ratio    (ratio_cur),
        .load     (commit),
        .cnt_next (cnt_next),
        .last     (last)
    );

    // A pending switch commits only on the last cycle of the running period,
    // so the new ratio always starts with a full high phase.
    always_comb begin
        // NOTE: every variable gets a default first so no path infers a latch.
        state_nxt = state;
        pend_nxt  = pend;
        sel_nxt   = cur_sel;
        commit    = 1'b0;
        done_nxt  = 1'b0;
        err_nxt   = 1'b0;
        unique case (state)
            SEL_IDLE: begin
                if (sel_req) begin
                    if (idx_ok) begin
                        pend_nxt  = sel_idx;
                        state_nxt = SEL_PEND;
                    end else begin
                        err_nxt = 1'b1;
                    end
                end
            end
            SEL_PEND: begin
                if (last) begin
                    commit    = 1'b1;
                    sel_nxt   = pend;
                    done_nxt  = 1'b1;
                    state_nxt = SEL_IDLE;
                end
            end
            default: state_nxt = SEL_IDLE;
        endcase
    end

    // Outputs are registered from the next count and next ratio, so they
    // describe the cycle being entered without any combinational path out.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= SEL_IDLE;
            pend     <= RST_SEL_V;
            cur_sel  <= RST_SEL_V;
            clk_out  <= 1'b0;
            clk_en   <= 1'b0;
            sel_done <= 1'b0;
            sel_err  <= 1'b0;
        end else begin
            state    <= state_nxt;
            pend     <= pend_nxt;
            cur_sel  <= sel_nxt;
            clk_out  <= (cnt_next < half_nxt);
            clk_en   <= (cnt_next == ratio_nxt - ONE);
            sel_done <= done_nxt;
            sel_err  <= err_nxt;
        end
    end

endmodule

// File: tb/tb_clk_div_sel_mux.sv
// Self-checking bench for clk_div_sel_mux: directed scenarios plus random
// requests, compared each cycle against a period-position reference model.
module tb_clk_div_sel_mux;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req_a = 1'b0, req_b = 1'b0;
    logic [1:0] idx_a = '0;
    logic [2:0] idx_b = '0;
    logic       busy_a, done_a, err_a, out_a, en_a;
    logic       busy_b, done_b, err_b, out_b, en_b;
    logic [1:0] cur_a;
    logic [2:0] cur_b;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    clk_div_sel_mux dut_a (
        .clk(clk), .rst(rst), .sel_req(req_a), .sel_idx(idx_a),
        .sel_busy(busy_a), .sel_done(done_a), .sel_err(err_a),
        .cur_sel(cur_a), .clk_out(out_a), .clk_en(en_a)
    );

    clk_div_sel_mux #(
        .NUM_SRC(5), .DIV_W(8),
        .DIV_LIST({8'd6, 8'd3, 8'd0, 8'd1, 8'd2}), .RST_SEL(3)
    ) dut_b (
        .clk(clk), .rst(rst), .sel_req(req_b), .sel_idx(idx_b),
        .sel_busy(busy_b), .sel_done(done_b), .sel_err(err_b),
        .cur_sel(cur_b), .clk_out(out_b), .clk_en(en_b)
    );

    // Reference model: position inside the current period plus pending index.
    int raw_tab [2][5] = '{'{2, 4, 8, 16, 0}, '{2, 1, 0, 3, 6}};
    int nsrc    [2]    = '{4, 5};
    int rst_sel [2]    = '{0, 3};
    int m_pos [2], m_cur [2], m_pend [2];
    bit m_rst [2], m_done [2], m_err [2];
    bit sb_on = 1'b0;

    function automatic int ratio_of(int u, int s);
        return (raw_tab[u][s] < 2) ? 2 : raw_tab[u][s];
    endfunction

    function automatic int exp_latency(int r, int p);
        return (p == r - 1) ? r + 1 : r - p;
    endfunction

    function automatic void model_step(int u, bit r, bit req, int idx);
        int rc;
        int old;
        if (r) begin
            m_rst[u]  = 1'b1;
            m_cur[u]  = rst_sel[u];
            m_pos[u]  = ratio_of(u, rst_sel[u]) - 1;
            m_pend[u] = -1;
            m_done[u] = 1'b0;
            m_err[u]  = 1'b0;
        end else begin
            rc        = ratio_of(u, m_cur[u]);
            old       = m_pend[u];
            m_rst[u]  = 1'b0;
            m_done[u] = 1'b0;
            m_err[u]  = 1'b0;
            if (old < 0 && req) begin
                if (idx < nsrc[u]) m_pend[u] = idx;
                else m_err[u] = 1'b1;
            end
            if (m_pos[u] == rc - 1) begin
                m_pos[u] = 0;
                if (old >= 0) begin
                    m_cur[u]  = old;
                    m_pend[u] = -1;
                    m_done[u] = 1'b1;
                end
            end else begin
                m_pos[u]++;
            end
        end
    endfunction

    function automatic logic [4:0] exp_flags(int u);
        int  rc;
        logic o, e;
        rc = ratio_of(u, m_cur[u]);
        o  = !m_rst[u] && (m_pos[u] < rc / 2);
        e  = !m_rst[u] && (m_pos[u] == rc - 1);
        return {o, e, (m_pend[u] >= 0), m_done[u], m_err[u]};
    endfunction

    always @(posedge clk) begin
        model_step(0, rst, req_a, int'(idx_a));
        model_step(1, rst, req_b, int'(idx_b));
        if (rst) sb_on = 1'b1;
    end

    // Cycle scoreboard, sampled on the falling edge.
    always @(negedge clk) begin
        if (sb_on) begin
            checks++;
            if ({out_a, en_a, busy_a, done_a, err_a} !== exp_flags(0)) begin
                failures++;
                $display("FAIL sb_flags_a t=%0t got=%b exp=%b (out,en,busy,done,err)",
                         $time, {out_a, en_a, busy_a, done_a, err_a}, exp_flags(0));
            end
            checks++;
            if (cur_a !== 2'(m_cur[0])) begin
                failures++;
                $display("FAIL sb_cur_a t=%0t got=%0d exp=%0d", $time, cur_a, m_cur[0]);
            end
            checks++;
            if ({out_b, en_b, busy_b, done_b, err_b} !== exp_flags(1)) begin
                failures++;
                $display("FAIL sb_flags_b t=%0t got=%b exp=%b (out,en,busy,done,err)",
                         $time, {out_b, en_b, busy_b, done_b, err_b}, exp_flags(1));
            end
            checks++;
            if (cur_b !== 3'(m_cur[1])) begin
                failures++;
                $display("FAIL sb_cur_b t=%0t got=%0d exp=%0d", $time, cur_b, m_cur[1]);
            end
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) tick();
        checks++;
        if ({out_a, en_a, busy_a, done_a, err_a, cur_a} !== 7'b0 || cur_b !== 3'd3) begin
            failures++;
            $display("FAIL reset_vals got=%b cur_b=%0d exp=0000000 cur_b=3",
                     {out_a, en_a, busy_a, done_a, err_a, cur_a}, cur_b);
        end
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (out_a !== 1'(i % 2 == 0) || en_a !== 1'(i % 2 == 1) || cur_a !== 2'd0) begin
                failures++;
                $display("FAIL reset_r2 i=%0d got out=%b en=%b cur=%0d exp out=%b en=%b cur=0",
                         i, out_a, en_a, cur_a, 1'(i % 2 == 0), 1'(i % 2 == 1));
            end
        end
    endtask

    task automatic test_switch_up();
        int p, exp_lat, lat;
        p       = m_pos[0];
        exp_lat = exp_latency(2, p);
        req_a = 1'b1; idx_a = 2'd3;
        tick();
        req_a = 1'b0; lat = 1;
        while (done_a !== 1'b1 && lat < 40) begin tick(); lat++; end
        checks++;
        if (lat !== exp_lat) begin
            failures++;
            $display("FAIL up_latency got=%0d exp=%0d", lat, exp_lat);
        end
        checks++;
        if (cur_a !== 2'd3) begin
            failures++;
            $display("FAIL up_cur_sel got=%0d exp=3", cur_a);
        end
        for (int i = 0; i < 16; i++) begin
            checks++;
            if (out_a !== 1'(i < 8) || en_a !== 1'(i == 15)) begin
                failures++;
                $display("FAIL up_r16 i=%0d got out=%b en=%b exp out=%b en=%b",
                         i, out_a, en_a, 1'(i < 8), 1'(i == 15));
            end
            tick();
        end
    endtask

    task automatic test_switch_down();
        int n, lat;
        logic prev_out, prev_en;
        n = 0;
        while (m_pos[0] != 3 && n < 40) begin tick(); n++; end
        req_a = 1'b1; idx_a = 2'd1;
        prev_out = out_a; prev_en = en_a;
        tick();
        req_a = 1'b0; lat = 1;
        while (done_a !== 1'b1 && lat < 40) begin
            prev_out = out_a; prev_en = en_a;
            tick(); lat++;
        end
        checks++;
        if (lat !== exp_latency(16, 3)) begin
            failures++;
            $display("FAIL down_latency got=%0d exp=%0d", lat, exp_latency(16, 3));
        end
        checks++;
        if (prev_out !== 1'b0 || prev_en !== 1'b1) begin
            failures++;
            $display("FAIL down_period_end got out=%b en=%b exp out=0 en=1", prev_out, prev_en);
        end
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (out_a !== 1'(i % 4 < 2) || cur_a !== 2'd1) begin
                failures++;
                $display("FAIL down_r4 i=%0d got out=%b cur=%0d exp out=%b cur=1",
                         i, out_a, cur_a, 1'(i % 4 < 2));
            end
            tick();
        end
    endtask

    task automatic test_busy_and_err();
        int lat;
        req_a = 1'b1; idx_a = 2'd2;
        tick();
        req_a = 1'b0;
        checks++;
        if (busy_a !== 1'b1) begin
            failures++;
            $display("FAIL busy_set got=%b exp=1", busy_a);
        end
        req_a = 1'b1; idx_a = 2'd0;
        tick();
        req_a = 1'b0; lat = 0;
        while (done_a !== 1'b1 && lat < 40) begin tick(); lat++; end
        checks++;
        if (cur_a !== 2'd2 || done_a !== 1'b1) begin
            failures++;
            $display("FAIL busy_ignore got cur=%0d done=%b exp cur=2 done=1", cur_a, done_a);
        end
        for (int i = 0; i < 10; i++) begin
            tick();
            checks++;
            if (busy_a !== 1'b0 || cur_a !== 2'd2) begin
                failures++;
                $display("FAIL busy_no_queue i=%0d got busy=%b cur=%0d exp busy=0 cur=2",
                         i, busy_a, cur_a);
            end
        end
        req_a = 1'b1; idx_a = 2'd2;
        tick();
        req_a = 1'b0; lat = 0;
        while (done_a !== 1'b1 && lat < 40) begin tick(); lat++; end
        checks++;
        if (done_a !== 1'b1 || cur_a !== 2'd2) begin
            failures++;
            $display("FAIL same_idx got done=%b cur=%0d exp done=1 cur=2", done_a, cur_a);
        end
        for (int k = 5; k < 8; k++) begin
            req_b = 1'b1; idx_b = 3'(k);
            tick();
            req_b = 1'b0;
            checks++;
            if (err_b !== 1'b1 || busy_b !== 1'b0 || cur_b !== 3'd3) begin
                failures++;
                $display("FAIL err_pulse idx=%0d got err=%b busy=%b cur=%0d exp err=1 busy=0 cur=3",
                         k, err_b, busy_b, cur_b);
            end
            tick();
            checks++;
            if (err_b !== 1'b0) begin
                failures++;
                $display("FAIL err_one_cycle idx=%0d got=%b exp=0", k, err_b);
            end
        end
    endtask

    task automatic test_odd_ratio();
        int tgt [3] = '{1, 2, 4};
        int r, lat;
        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            checks++;
            if (out_b !== 1'(i % 3 == 0) || en_b !== 1'(i % 3 == 2)) begin
                failures++;
                $display("FAIL odd_r3 i=%0d got out=%b en=%b exp out=%b en=%b",
                         i, out_b, en_b, 1'(i % 3 == 0), 1'(i % 3 == 2));
            end
        end
        foreach (tgt[t]) begin
            r = ratio_of(1, tgt[t]);
            req_b = 1'b1; idx_b = 3'(tgt[t]);
            tick();
            req_b = 1'b0; lat = 1;
            while (done_b !== 1'b1 && lat < 40) begin tick(); lat++; end
            for (int i = 0; i < 2 * r; i++) begin
                checks++;
                if (out_b !== 1'(i % r < r / 2) || cur_b !== 3'(tgt[t])) begin
                    failures++;
                    $display("FAIL odd_switch idx=%0d i=%0d got out=%b cur=%0d exp out=%b cur=%0d",
                             tgt[t], i, out_b, cur_b, 1'(i % r < r / 2), tgt[t]);
                end
                tick();
            end
        end
    endtask

    task automatic test_reset_mid_switch();
        req_a = 1'b1; idx_a = 2'd3;
        tick();
        req_a = 1'b0;
        checks++;
        if (busy_a !== 1'b1) begin
            failures++;
            $display("FAIL mid_busy got=%b exp=1", busy_a);
        end
        rst = 1'b1;
        tick();
        checks++;
        if ({out_a, en_a, busy_a, done_a, err_a, cur_a} !== 7'b0) begin
            failures++;
            $display("FAIL mid_reset_vals got=%b exp=0000000", {out_a, en_a, busy_a, done_a, err_a, cur_a});
        end
        tick();
        rst = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick();
            checks++;
            if (done_a !== 1'b0 || cur_a !== 2'd0 || out_a !== 1'(i % 2 == 0)) begin
                failures++;
                $display("FAIL mid_after i=%0d got done=%b cur=%0d out=%b exp done=0 cur=0 out=%b",
                         i, done_a, cur_a, out_a, 1'(i % 2 == 0));
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            tick();
            req_a = ($urandom_range(0, 2) == 0);
            idx_a = 2'($urandom_range(0, 3));
            req_b = ($urandom_range(0, 2) == 0);
            idx_b = 3'($urandom_range(0, 7));
            rst   = ($urandom_range(0, 149) == 0);
        end
        tick();
        rst = 1'b0; req_a = 1'b0; req_b = 1'b0;
        repeat (20) tick();
    endtask

    initial begin
        test_reset();
        test_switch_up();
        test_switch_down();
        test_busy_and_err();
        test_odd_ratio();
        test_reset_mid_switch();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog t=%0t exp=finish before limit", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
